// File: rtl/one_wire_pkg.sv
// Shared 1-Wire definitions: default standard-speed timings, command codes, FSM states.
package one_wire_pkg;

    // Default timing (µs) and clock rate (cycles per µs)
    localparam int OW_CLK_MHZ = 10;
    localparam int OW_T_RSTL  = 480;
    localparam int OW_T_RSTH  = 480;
    localparam int OW_T_PDH   = 15;
    localparam int OW_T_PDL   = 60;
    localparam int OW_T_SLOT  = 60;
    localparam int OW_T_REC   = 1;
    localparam int OW_T_W1L   = 6;
    localparam int OW_T_W0L   = 60;

    // Command select values on cmd_rst
    localparam logic OW_CMD_RST = 1'b1;
    localparam logic OW_CMD_WR  = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RST_LOW = 3'd1,
        ST_RST_REL = 3'd2,
        ST_WR_LOW  = 3'd3,
        ST_WR_REL  = 3'd4,
        ST_WR_REC  = 3'd5,
        ST_DONE    = 3'd6
    } ow_state_t;

    function automatic int ow_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/one_wire_phase_timer.sv
// Phase timer: load a cycle count, count down to zero, flag expiry while at zero.
// A phase of N cycles is obtained by loading N-1.
module one_wire_phase_timer
    import one_wire_pkg::*;
#(
    parameter int unsigned W = 13
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_count,
    output logic         o_expire
);

    logic [W-1:0] r_count;

    // Load takes priority; otherwise count down and hold at zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_count  = r_count;
    assign o_expire = (r_count == '0);

endmodule

// File: rtl/one_wire_tx.sv
// 1-Wire bus master transmit engine (standard speed): reset/presence and byte write.
// Drives the open-drain pad through ow_drive_low; read slots live in the RX path.
module one_wire_tx
    import one_wire_pkg::*;
#(
    parameter int CLK_MHZ = OW_CLK_MHZ,
    parameter int T_RSTL  = OW_T_RSTL,
    parameter int T_RSTH  = OW_T_RSTH,
    parameter int T_PDH   = OW_T_PDH,
    parameter int T_PDL   = OW_T_PDL,
    parameter int T_SLOT  = OW_T_SLOT,
    parameter int T_REC   = OW_T_REC,
    parameter int T_W1L   = OW_T_W1L,
    parameter int T_W0L   = OW_T_W0L
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rst,
    input  logic [7:0] cmd_data,
    input  logic       ow_in,
    output logic       ow_drive_low,
    output logic       done,
    output logic       presence,
    output logic       busy
);

    // Phase lengths in clock cycles
    localparam int RSTL_CYC  = T_RSTL * CLK_MHZ;
    localparam int RSTH_CYC  = T_RSTH * CLK_MHZ;
    localparam int PRES_CYC  = (T_PDH + T_PDL) * CLK_MHZ;
    localparam int W1L_CYC   = T_W1L * CLK_MHZ;
    localparam int W0L_CYC   = T_W0L * CLK_MHZ;
    localparam int W1REL_CYC = (T_SLOT - T_W1L) * CLK_MHZ;
    localparam int W0REL_CYC = (T_SLOT - T_W0L) * CLK_MHZ;
    localparam int REC_CYC   = T_REC * CLK_MHZ;

    localparam bit W1_HAS_REL = (W1REL_CYC > 0);
    localparam bit W0_HAS_REL = (W0REL_CYC > 0);

    localparam int MAX_CYC = ow_max(ow_max(RSTL_CYC, RSTH_CYC),
                                    ow_max(ow_max(W1L_CYC, W0L_CYC),
                                           ow_max(ow_max(W1REL_CYC, W0REL_CYC), REC_CYC)));
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] LD_RSTL  = CNT_W'(RSTL_CYC - 1);
    localparam logic [CNT_W-1:0] LD_RSTH  = CNT_W'(RSTH_CYC - 1);
    localparam logic [CNT_W-1:0] LD_W1L   = CNT_W'(W1L_CYC - 1);
    localparam logic [CNT_W-1:0] LD_W0L   = CNT_W'(W0L_CYC - 1);
    localparam logic [CNT_W-1:0] LD_W1REL = CNT_W'(W1_HAS_REL ? W1REL_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] LD_W0REL = CNT_W'(W0_HAS_REL ? W0REL_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] LD_REC   = CNT_W'(REC_CYC - 1);
    // Counter value in RST_REL at release cycle PRES_CYC (cycle 0 = first released cycle)
    localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(RSTH_CYC - 1 - PRES_CYC);

    ow_state_t        r_state;
    ow_state_t        w_state_next;
    logic [7:0]       r_shift;
    logic [2:0]       r_bit_idx;
    logic             r_drive;
    logic             r_presence;
    logic             r_sync_meta;
    logic             r_ow_in_s;

    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic [CNT_W-1:0] w_count;
    logic             w_expire;
    logic             w_accept;
    logic             w_shift;
    logic             w_sample;

    one_wire_phase_timer #(
        .W (CNT_W)
    ) u_timer (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_count    (w_count),
        .o_expire   (w_expire)
    );

    // Two-flop synchroniser for the raw bus level (idle bus reads high)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_meta <= 1'b1;
            r_ow_in_s   <= 1'b1;
        end else begin
            r_sync_meta <= ow_in;
            r_ow_in_s   <= r_sync_meta;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, phase-timer load and datapath strobes
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_val   = '0;
        w_accept     = 1'b0;
        w_shift      = 1'b0;
        w_sample     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    w_load   = 1'b1;
                    case (cmd_rst)
                        OW_CMD_RST: begin
                            w_state_next = ST_RST_LOW;
                            w_load_val   = LD_RSTL;
                        end
                        OW_CMD_WR: begin
                            w_state_next = ST_WR_LOW;
                            w_load_val   = cmd_data[0] ? LD_W1L : LD_W0L;
                        end
                    endcase
                end
            end
            ST_RST_LOW: begin
                if (w_expire) begin
                    w_state_next = ST_RST_REL;
                    w_load       = 1'b1;
                    w_load_val   = LD_RSTH;
                end
            end
            ST_RST_REL: begin
                w_sample = (w_count == SAMPLE_CNT);
                if (w_expire) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_WR_LOW: begin
                if (w_expire) begin
                    // A release phase of zero length is skipped straight into recovery
                    w_load = 1'b1;
                    if (r_shift[0] ? W1_HAS_REL : W0_HAS_REL) begin
                        w_state_next = ST_WR_REL;
                        w_load_val   = r_shift[0] ? LD_W1REL : LD_W0REL;
                    end else begin
                        w_state_next = ST_WR_REC;
                        w_load_val   = LD_REC;
                    end
                end
            end
            ST_WR_REL: begin
                if (w_expire) begin
                    w_state_next = ST_WR_REC;
                    w_load       = 1'b1;
                    w_load_val   = LD_REC;
                end
            end
            ST_WR_REC: begin
                if (w_expire) begin
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = ST_DONE;
                    end else begin
                        // Next slot starts immediately; its bit is the one about to shift into [0]
                        w_state_next = ST_WR_LOW;
                        w_shift      = 1'b1;
                        w_load       = 1'b1;
                        w_load_val   = r_shift[1] ? LD_W1L : LD_W0L;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Byte shifter and bit index: captured at accept, advanced at each slot boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_bit_idx <= '0;
        end else if (w_accept) begin
            r_shift   <= cmd_data;
            r_bit_idx <= '0;
        end else if (w_shift) begin
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
        end
    end

    // Registered pad drive: low exactly while the next state is a low phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drive <= 1'b0;
        end else begin
            r_drive <= (w_state_next == ST_RST_LOW) || (w_state_next == ST_WR_LOW);
        end
    end

    // Presence flag: updated only at the sample point of the reset release window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presence <= 1'b0;
        end else if (w_sample) begin
            r_presence <= ~r_ow_in_s;
        end
    end

    assign ow_drive_low = r_drive;
    assign presence     = r_presence;
    assign cmd_ready    = (r_state == ST_IDLE);
    assign busy         = (r_state != ST_IDLE);
    assign done         = (r_state == ST_DONE);

endmodule

// File: tb/tb_one_wire_tx.sv
// Self-checking bench for one_wire_tx: cycle-level waveform model plus literal timing pins.
module tb_one_wire_tx;

    localparam int CLK = 10;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rst;
    logic [7:0] cmd_data;
    logic       ow_in;
    logic       ow_drive_low;
    logic       done;
    logic       presence;
    logic       busy;

    one_wire_tx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_rst      (cmd_rst),
        .cmd_data     (cmd_data),
        .ow_in        (ow_in),
        .ow_drive_low (ow_drive_low),
        .done         (done),
        .presence     (presence),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wired-AND bus: master pull-down and optional device pull-down
    logic dev_en;
    logic dev_pull;
    assign ow_in = ~ow_drive_low & ~dev_pull;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Device: pulls low 400..999 cycles after the end of a long (reset) low
    initial begin
        int lowcnt;
        int since;
        lowcnt   = 0;
        since    = -1;
        dev_pull = 1'b0;
        forever begin
            @(negedge clk);
            if (ow_drive_low) begin
                lowcnt++;
                since = -1;
            end else begin
                if (lowcnt >= 4000) since = 0;
                else if (since >= 0 && since < 100000) since++;
                lowcnt = 0;
            end
            dev_pull = dev_en && (since >= 400) && (since < 1000);
        end
    end

    // Expected per-cycle outputs while a sequence runs
    typedef struct packed {
        logic drv;
        logic dn;
        logic bsy;
    } exp_t;

    exp_t q[$];
    int   neg_cnt = 0;
    int   done_cnt = 0;
    int   acc_log[$];
    int   done_log[$];
    int   pl_len[$];
    int   pl_start[$];
    logic exp_pres = 1'b0;
    logic pend_rst = 1'b0;
    logic pend_pres = 1'b0;

    // Build the expected waveform of one command from the protocol durations
    task automatic push_seq(input logic r, input logic [7:0] d);
        exp_t e;
        if (r) begin
            e = '{drv: 1'b1, dn: 1'b0, bsy: 1'b1};
            for (int i = 0; i < 480 * CLK; i++) q.push_back(e);
            e = '{drv: 1'b0, dn: 1'b0, bsy: 1'b1};
            for (int i = 0; i < 480 * CLK; i++) q.push_back(e);
        end else begin
            for (int b = 0; b < 8; b++) begin
                int low;
                int rel;
                low = d[b] ? 6 * CLK : 60 * CLK;
                rel = ((60 * CLK > low) ? 60 * CLK - low : 0) + 1 * CLK;
                e = '{drv: 1'b1, dn: 1'b0, bsy: 1'b1};
                for (int i = 0; i < low; i++) q.push_back(e);
                e = '{drv: 1'b0, dn: 1'b0, bsy: 1'b1};
                for (int i = 0; i < rel; i++) q.push_back(e);
            end
        end
        e = '{drv: 1'b0, dn: 1'b1, bsy: 1'b1};
        q.push_back(e);
        pend_rst  = r;
        pend_pres = dev_en;
    endtask

    // Compare process: every falling edge, DUT outputs against the model
    initial begin
        exp_t e;
        logic prev_drv;
        int   cur_start;
        int   cur_len;
        prev_drv  = 1'b0;
        cur_start = 0;
        cur_len   = 0;
        forever begin
            @(negedge clk);
            neg_cnt++;
            if (ow_drive_low) begin
                if (!prev_drv) begin
                    cur_start = neg_cnt;
                    cur_len   = 0;
                end
                cur_len++;
            end else if (prev_drv) begin
                pl_len.push_back(cur_len);
                pl_start.push_back(cur_start);
            end
            prev_drv = ow_drive_low;
            if (done) begin
                done_cnt++;
                done_log.push_back(neg_cnt);
            end
            if (!rst_n) begin
                q.delete();
                exp_pres = 1'b0;
                chk("rst_drive", int'(ow_drive_low), 0);
                chk("rst_ready", int'(cmd_ready), 1);
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_presence", int'(presence), 0);
            end else if (q.size() > 0) begin
                e = q.pop_front();
                chk("drive", int'(ow_drive_low), int'(e.drv));
                chk("done", int'(done), int'(e.dn));
                chk("busy", int'(busy), int'(e.bsy));
                chk("ready_busy", int'(cmd_ready), 0);
                if (e.dn) begin
                    if (pend_rst) exp_pres = pend_pres;
                    chk("presence_done", int'(presence), int'(exp_pres));
                end
            end else begin
                chk("idle_ready", int'(cmd_ready), 1);
                chk("idle_drive", int'(ow_drive_low), 0);
                chk("idle_done", int'(done), 0);
                chk("idle_busy", int'(busy), 0);
                chk("idle_presence", int'(presence), int'(exp_pres));
                if (cmd_valid) begin
                    acc_log.push_back(neg_cnt);
                    push_seq(cmd_rst, cmd_data);
                end
            end
        end
    end

    task automatic clear_logs();
        acc_log.delete();
        done_log.delete();
        pl_len.delete();
        pl_start.delete();
    endtask

    // Raise cmd_valid and wait (bounded) for the handshake edge
    task automatic send(input logic r, input logic [7:0] d, input bit hold);
        int n;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_rst   = r;
        cmd_data  = d;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", int'(cmd_ready), 1);
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", int'(done_cnt >= target), 1);
        @(negedge clk);
    endtask

    initial begin
        int d0;
        int w_a5[8];
        int w_3c[8];
        w_a5 = '{60, 600, 60, 600, 600, 60, 600, 60};
        w_3c = '{600, 600, 60, 60, 60, 60, 600, 600};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_rst   = 1'b0;
        cmd_data  = '0;
        dev_en    = 1'b0;
        repeat (3) @(negedge clk);
        chk("por_drive", int'(ow_drive_low), 0);
        chk("por_ready", int'(cmd_ready), 1);
        chk("por_presence", int'(presence), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Reset, no device
        clear_logs();
        d0 = done_cnt;
        send(1'b1, 8'h00, 1'b0);
        wait_done(d0 + 1, 12000);
        chk("nodev_presence", int'(presence), 0);
        chk("nodev_low_len", pl_len.size() > 0 ? pl_len[0] : -1, 4800);
        chk("nodev_latency", done_log[0] - acc_log[0], 9601);

        // Reset with responding device
        repeat (5) @(negedge clk);
        dev_en = 1'b1;
        clear_logs();
        d0 = done_cnt;
        send(1'b1, 8'h00, 1'b0);
        wait_done(d0 + 1, 12000);
        repeat (3) @(negedge clk);
        chk("dev_presence", int'(presence), 1);
        chk("dev_done_once", done_cnt - d0, 1);
        chk("dev_low_len", pl_len.size() > 0 ? pl_len[0] : -1, 4800);
        chk("dev_low_start", pl_start.size() > 0 ? pl_start[0] - acc_log[0] : -1, 1);
        chk("dev_latency", done_log[0] - acc_log[0], 9601);
        dev_en = 1'b0;

        // Write 0xA5 with cmd_valid held and data changed while busy, then 0x3C back-to-back
        repeat (5) @(negedge clk);
        clear_logs();
        d0 = done_cnt;
        send(1'b0, 8'hA5, 1'b1);
        cmd_data = 8'h3C;
        wait_done(d0 + 1, 6000);
        begin
            int n;
            n = 0;
            while (acc_log.size() < 2 && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("b2b_accept_seen", acc_log.size(), 2);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_done(d0 + 2, 6000);
        repeat (3) @(negedge clk);
        chk("wr_pulse_count", pl_len.size(), 16);
        if (pl_len.size() == 16) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("a5_low%0d", i), pl_len[i], w_a5[i]);
                chk($sformatf("a5_start%0d", i), pl_start[i] - pl_start[0], 610 * i);
                chk($sformatf("3c_low%0d", i), pl_len[8 + i], w_3c[i]);
                chk($sformatf("3c_start%0d", i), pl_start[8 + i] - pl_start[8], 610 * i);
            end
            chk("b2b_gap", pl_start[8] - pl_start[7], 612);
        end
        chk("a5_latency", done_log[0] - acc_log[0], 4881);
        chk("b2b_accept_cycle", acc_log[1] - done_log[0], 1);
        chk("wr_presence_kept", int'(presence), 1);
        chk("wr_done_count", done_cnt - d0, 2);

        // Asynchronous reset in the middle of a write-0 low phase
        repeat (5) @(negedge clk);
        clear_logs();
        send(1'b0, 8'h00, 1'b0);
        repeat (300) @(negedge clk);
        chk("pre_rst_drive", int'(ow_drive_low), 1);
        d0 = done_cnt;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_release", int'(ow_drive_low), 0);
        chk("async_busy", int'(busy), 0);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (700) @(negedge clk);
        chk("no_done_after_rst", done_cnt - d0, 0);
        chk("post_rst_ready", int'(cmd_ready), 1);
        chk("post_rst_presence", int'(presence), 0);

        clear_logs();
        d0 = done_cnt;
        send(1'b0, 8'hFF, 1'b0);
        wait_done(d0 + 1, 6000);
        repeat (3) @(negedge clk);
        chk("ff_pulse_count", pl_len.size(), 8);
        if (pl_len.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("ff_low%0d", i), pl_len[i], 60);
                chk($sformatf("ff_start%0d", i), pl_start[i] - acc_log[0], 1 + 610 * i);
            end
        end
        chk("ff_latency", done_log[0] - acc_log[0], 4881);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time guard
    initial begin
        #5000000;
        errors++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
